logic_unit_arbiter: RTL and testbench

//  Shares one 32-bit bitwise logic unit (AND/OR, optional XOR) between NUM_REQ requesters.

---
 rtl/logic_unit_arbiter_pkg.sv | 26 ++
 rtl/logic_unit_arbiter_rr.sv | 39 +++
 rtl/logic_unit_arbiter.sv | 155 +++++++++++++++
 tb/tb_logic_unit_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_arbiter_pkg.sv
// ============================================================================
//  Module      : logic_unit_arbiter_pkg
//  Description : Shared op codes, FSM state encoding and id width for the
//                logic_unit_arbiter block.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package logic_unit_arbiter_pkg;

  localparam logic [1:0] LOP_AND = 2'b00;
  localparam logic [1:0] LOP_OR  = 2'b01;
  localparam logic [1:0] LOP_XOR = 2'b10;
  localparam logic [1:0] LOP_ILL = 2'b11;

  localparam int unsigned ID_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

`default_nettype wire

// File: rtl/logic_unit_arbiter_rr.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin grant: the first requester at or
//                after the pointer, wrapping at NUM_REQ. Produces a one-hot grant.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] grant_o
);

  logic found;

  // Scan offsets from the pointer; compare against constant indices so no
  // variable bit-select is needed.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (en_i && !found && req_i[i] && (((int'(ptr_i) + off) % NUM_REQ) == i)) begin
          grant_o[i] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/logic_unit_arbiter.sv
// ============================================================================
//  Module      : logic_unit_arbiter
//  Description : Shares one bitwise logic unit (AND/OR, optional XOR) between
//                NUM_REQ requesters with round-robin arbitration.
//                Define LOGIC_ARB_XOR_EN to enable the XOR op code.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [2:0]               resp_id,
  output logic [WIDTH-1:0]         resp_data,
  output logic                     resp_err,
  output logic                     busy
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [1:0]        op_q, op_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]   resp_id_q, resp_id_d;
  logic [WIDTH-1:0]  resp_data_q, resp_data_d;
  logic              resp_err_q, resp_err_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gnt_idx;
  logic               arb_en;

  // Grants are suppressed while reset is high so no handshake is lost.
  assign arb_en = (state_q == ST_IDLE) && !reset;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .en_i    (arb_en),
    .grant_o (grant)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    gnt_idx      = '0;

    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) gnt_idx = ID_W'(i);
    end

    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
              op_d = req_op[2*i +: 2];
              a_d  = req_a[WIDTH*i +: WIDTH];
              b_d  = req_b[WIDTH*i +: WIDTH];
            end
          end
          id_d    = gnt_idx;
          ptr_d   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        resp_valid_d = 1'b1;
        resp_id_d    = id_q;
        resp_err_d   = 1'b0;
        resp_data_d  = '0;
        case (op_q)
          LOP_AND: resp_data_d = a_q & b_q;
          LOP_OR:  resp_data_d = a_q | b_q;
`ifdef LOGIC_ARB_XOR_EN
          LOP_XOR: resp_data_d = a_q ^ b_q;
`else
          LOP_XOR: resp_err_d  = 1'b1;
`endif
          LOP_ILL: resp_err_d  = 1'b1;
        endcase
        state_d = ST_DONE;
      end

      ST_DONE: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = grant;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
// ============================================================================
//  Module      : tb_logic_unit_arbiter
//  Description : Randomized and directed scoreboard bench for logic_unit_arbiter
//                (NUM_REQ=4), checked against a behavioural reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_logic_unit_arbiter;

  localparam int NR = 4;
  localparam int W  = 32;
`ifdef LOGIC_ARB_XOR_EN
  localparam bit XOR_EN = 1'b1;
`else
  localparam bit XOR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]  id;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic            clock;
  logic            reset;
  logic [NR-1:0]   pend;
  logic [2*NR-1:0] req_op_v;
  logic [W*NR-1:0] req_a_v, req_b_v;
  logic [NR-1:0]   req_ready;
  logic            resp_valid, resp_ready;
  logic [2:0]      resp_id;
  logic [W-1:0]    resp_data;
  logic            resp_err, busy;

  logic [1:0]  op_m [NR];
  logic [31:0] a_m  [NR];
  logic [31:0] b_m  [NR];

  int            errs, checks;
  int            phase, mptr, m_g;
  logic [NR-1:0] m_exp_rdy, acc_mask;
  logic          mon_en, post_rst;
  exp_t          sb[$];
  int            glog[$];

  logic_unit_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (pend),
    .req_op     (req_op_v),
    .req_a      (req_a_v),
    .req_b      (req_b_v),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req_op_v[2*i +: 2] = op_m[i];
      req_a_v[W*i +: W]  = a_m[i];
      req_b_v[W*i +: W]  = b_m[i];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int id, input logic [1:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    r.id   = 3'(id);
    r.data = '0;
    r.err  = 1'b0;
    if (op == 2'd0)                r.data = a & b;
    else if (op == 2'd1)           r.data = a | b;
    else if (op == 2'd2 && XOR_EN) r.data = a ^ b;
    else                           r.err  = 1'b1;
    return r;
  endfunction

  // Monitor: reference model of arbitration, timing and results.
  always @(negedge clock) begin
    if (mon_en) begin
      m_g = -1;
      if (!reset && phase == 0) begin
        for (int k = 0; k < NR; k++) begin
          if (m_g < 0 && pend[(mptr + k) % NR]) m_g = (mptr + k) % NR;
        end
      end
      m_exp_rdy = (m_g >= 0) ? (NR'(1) << m_g) : '0;
      chk("req_ready", req_ready, m_exp_rdy);
      chk("resp_valid", resp_valid, (phase == 2));
      chk("busy", busy, (phase != 0));
      if (phase == 2 && sb.size() > 0) begin
        chk("resp_id", resp_id, sb[0].id);
        chk("resp_data", resp_data, sb[0].data);
        chk("resp_err", resp_err, sb[0].err);
      end
      if (post_rst && !reset) begin
        chk("rst_resp_id", resp_id, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_err", resp_err, 0);
        post_rst = 1'b0;
      end
      acc_mask = req_ready & {NR{~reset}};
      if (reset) begin
        phase    = 0;
        mptr     = 0;
        sb.delete();
        post_rst = 1'b1;
      end else begin
        case (phase)
          0: if (m_g >= 0) begin
            sb.push_back(model(m_g, op_m[m_g], a_m[m_g], b_m[m_g]));
            glog.push_back(m_g);
            mptr  = (m_g + 1) % NR;
            phase = 1;
          end
          1: phase = 2;
          default: if (resp_ready) begin
            void'(sb.pop_front());
            phase = 0;
          end
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    pend = pend & ~acc_mask;
  endtask

  task automatic issue(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    op_m[i] = op;
    a_m[i]  = a;
    b_m[i]  = b;
    pend[i] = 1'b1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (!(pend == '0 && phase == 0) && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) begin
      checks++;
      errs++;
      $display("FAIL drain_timeout: pend=%b phase=%0d expected idle", pend, phase);
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (phase != 2 && k < 20) begin
      tick();
      k++;
    end
    if (k >= 20) begin
      checks++;
      errs++;
      $display("FAIL wait_done_timeout: phase=%0d expected 2", phase);
    end
  endtask

  initial begin
    errs = 0; checks = 0; phase = 0; mptr = 0;
    mon_en = 1'b0; post_rst = 1'b0; acc_mask = '0;
    reset = 1'b1; resp_ready = 1'b0; pend = '0;
    for (int i = 0; i < NR; i++) begin
      op_m[i] = '0; a_m[i] = '0; b_m[i] = '0;
    end
    @(posedge clock);
    #1;
    mon_en = 1'b1;
    tick();
    reset = 1'b0;

    // Single OR request from requester 0
    resp_ready = 1'b1;
    issue(0, 2'b01, 32'hF0F0_0000, 32'h0000_0F0F);
    drain();

    // Two persistent AND requesters alternate
    glog.delete();
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i]) issue(i, 2'b00, $urandom, $urandom);
      end
      tick();
    end
    drain();
    chk("t2_count_ok", (glog.size() >= 4), 1);
    for (int k = 0; k < 4; k++) chk("t2_order", glog[k], (k + 1) % 2);

    // Back-pressure: consumer stalls for 5 cycles while another request waits
    resp_ready = 1'b0;
    issue(1, 2'(($urandom % 2)), $urandom, $urandom);
    wait_done();
    issue(0, 2'b01, $urandom, $urandom);
    repeat (5) tick();
    resp_ready = 1'b1;
    drain();

    // XOR and illegal op codes
    issue(0, 2'b10, 32'hFFFF_0000, 32'hFF00_FF00);
    issue(1, 2'b11, $urandom, $urandom);
    drain();

    // Reset while the result is held
    resp_ready = 1'b0;
    issue(3, 2'b01, $urandom, $urandom);
    wait_done();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    resp_ready = 1'b1;
    issue(2, 2'b00, $urandom, $urandom);
    issue(1, 2'b01, $urandom, $urandom);
    drain();

    // Pointer wrap: move pointer to 3, then all four valid
    issue(2, 2'b00, $urandom, $urandom);
    drain();
    glog.delete();
    for (int i = 0; i < NR; i++) issue(i, 2'($urandom % 4), $urandom, $urandom);
    drain();
    for (int k = 0; k < 4; k++) chk("t6_order", glog[k], (3 + k) % 4);

    // Randomized traffic with drops and back-pressure
    for (int c = 0; c < 600; c++) begin
      tick();
      resp_ready = ($urandom % 3) != 0;
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && ($urandom % 4) == 0)
          issue(i, 2'($urandom % 4), $urandom, $urandom);
        else if (pend[i] && ($urandom % 32) == 0)
          pend[i] = 1'b0;
      end
    end
    resp_ready = 1'b1;
    drain();
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end

endmodule

`default_nettype wire
